// File: rtl/full_adder_reg_pkg.sv
// Datapath constants shared by arithmetic leaves.
// Holds the default adder width; full_adder_reg keeps its own WIDTH parameter.
package full_adder_reg_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder cell.
// Ports: a, b, c_in (inputs) -> sum, c_out (outputs).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic p;

    assign p     = a ^ b;
    assign sum   = p ^ c_in;
    assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {c_out,sum} <= a + b + c_in each clock.
// Ports: clk, rst (async high), a, b, c_in -> sum, c_out (flopped).
module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum_c[i]),
            .c_out (carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= sum_c;
            c_out <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and random checks of full_adder_reg at WIDTH 1, 8 and 16.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a1, b1, ci1, s1, co1;
    logic [7:0] a8, b8, s8;
    logic       ci8, co8;
    logic [15:0] a16, b16, s16;
    logic        ci16, co16;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] sb[$];

    always #5 clk = ~clk;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1),
        .sum(s1), .c_out(co1)
    );

    full_adder_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8),
        .sum(s8), .c_out(co8)
    );

    full_adder_reg #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(ci16),
        .sum(s16), .c_out(co16)
    );

    task automatic check(input string tag, input logic [16:0] obs,
                         input logic [16:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step1(input logic [2:0] abc, input logic [1:0] exp);
        @(negedge clk);
        {a1, b1, ci1} = abc;
        @(posedge clk);
        #1;
        check($sformatf("w1 abc=%b", abc), {15'd0, co1, s1}, {15'd0, exp});
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [8:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; ci8 = ci;
        @(posedge clk);
        #1;
        check($sformatf("w8 %h+%h+%b", a, b, ci), {8'd0, co8, s8},
              {8'd0, exp});
    endtask

    initial begin
        logic [16:0] exp16;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        a16 = '0; b16 = '0; ci16 = 1'b0;

        // reset held across edges with all-ones inputs
        #2;
        check("rst w1", {15'd0, co1, s1}, 17'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst held w1", {15'd0, co1, s1}, 17'd0);
        check("rst held w16", {co16, s16}, 17'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst release w1", {15'd0, co1, s1}, 17'd3);

        // async reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst w1", {15'd0, co1, s1}, 17'd0);
        @(negedge clk);
        rst = 1'b0;

        // exhaustive 1-bit sweep
        step1(3'b000, 2'b00);
        step1(3'b100, 2'b01);
        step1(3'b010, 2'b01);
        step1(3'b001, 2'b01);
        step1(3'b110, 2'b10);
        step1(3'b011, 2'b10);
        step1(3'b101, 2'b10);
        step1(3'b111, 2'b11);

        // 8-bit wrap and carry boundaries
        step8(8'hFF, 8'h00, 1'b1, 9'h100);
        step8(8'h7F, 8'h01, 1'b0, 9'h080);
        step8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        step8(8'h00, 8'h00, 1'b0, 9'h000);
        step8(8'hA5, 8'h5A, 1'b0, 9'h0FF);
        step8(8'h80, 8'h80, 1'b0, 9'h100);

        // 16-bit back-to-back random with scoreboard
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            ci16 = 1'($urandom);
            sb.push_back({1'b0, a16} + {1'b0, b16} + {16'd0, ci16});
            @(posedge clk);
            #1;
            exp16 = sb.pop_front();
            check($sformatf("w16 #%0d", i), {co16, s16}, exp16);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
